// File: rtl/tl_ul_pkg.sv
// Shared TileLink UL definitions: channel opcodes, default widths and the
// slave FSM state encoding used by tilelink_ul_slave_mem.
package tl_ul_pkg;

  // Default widths
  localparam int TL_ADDR_WIDTH_DEF   = 64;
  localparam int TL_DATA_WIDTH_DEF   = 64;
  localparam int TL_SOURCE_WIDTH_DEF = 3;
  localparam int TL_SINK_WIDTH_DEF   = 3;
  localparam int TL_OPCODE_WIDTH_DEF = 3;
  localparam int TL_PARAM_WIDTH_DEF  = 3;
  localparam int TL_SIZE_WIDTH_DEF   = 8;

  // A-channel opcodes
  localparam logic [2:0] PUT_FULL_DATA_A    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL_DATA_A = 3'd1;
  localparam logic [2:0] ARITHMETIC_DATA_A  = 3'd2;
  localparam logic [2:0] LOGICAL_DATA_A     = 3'd3;
  localparam logic [2:0] GET_A              = 3'd4;
  localparam logic [2:0] INTENT_A           = 3'd5;
  localparam logic [2:0] ACQUIRE_BLOCK_A    = 3'd6;
  localparam logic [2:0] ACQUIRE_PERM_A     = 3'd7;

  // D-channel opcodes
  localparam logic [2:0] ACCESS_ACK_D      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA_D = 3'd1;
  localparam logic [2:0] HINT_ACK_D        = 3'd2;
  localparam logic [2:0] GRANT_D           = 3'd4;
  localparam logic [2:0] GRANT_DATA_D      = 3'd5;
  localparam logic [2:0] RELEASE_ACK_D     = 3'd6;

  // Slave FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } slave_state_e;

endpackage

// File: rtl/tl_ul_slave_ram.sv
// Synchronous single-port RAM with byte-enable writes and a registered read
// port. Contents are intentionally never reset.
module tl_ul_slave_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int BW    = WIDTH / 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [BW-1:0]    be,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Byte-lane write and read-before-write data capture on enabled cycles
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BW; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/tilelink_ul_slave_mem.sv
// TileLink UL manager backed by a word-addressed, byte-maskable memory with a
// programmable response latency. One request is outstanding at a time.
// Build option: define TL_UL_SLAVE_PARTIAL_EN to support PutPartialData;
// without it opcode 1 is answered with an error and no write.
module tilelink_ul_slave_mem
  import tl_ul_pkg::*;
#(
  parameter int                       TL_ADDR_WIDTH   = 64,
  parameter int                       TL_DATA_WIDTH   = 64,
  parameter int                       TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
  parameter int                       TL_SOURCE_WIDTH = 3,
  parameter int                       TL_SINK_WIDTH   = 3,
  parameter int                       TL_OPCODE_WIDTH = 3,
  parameter int                       TL_PARAM_WIDTH  = 3,
  parameter int                       TL_SIZE_WIDTH   = 8,
  parameter int                       MEM_DEPTH       = 256,
  parameter logic [TL_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int                       RESP_LATENCY    = 2,
  parameter int                       SINK_ID         = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [TL_OPCODE_WIDTH-1:0] a_opcode,
  input  logic [TL_PARAM_WIDTH-1:0]  a_param,
  input  logic [TL_ADDR_WIDTH-1:0]   a_address,
  input  logic [TL_SIZE_WIDTH-1:0]   a_size,
  input  logic [TL_STRB_WIDTH-1:0]   a_mask,
  input  logic [TL_DATA_WIDTH-1:0]   a_data,
  input  logic [TL_SOURCE_WIDTH-1:0] a_source,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [TL_OPCODE_WIDTH-1:0] d_opcode,
  output logic [TL_PARAM_WIDTH-1:0]  d_param,
  output logic [TL_SIZE_WIDTH-1:0]   d_size,
  output logic [TL_SINK_WIDTH-1:0]   d_sink,
  output logic [TL_SOURCE_WIDTH-1:0] d_source,
  output logic [TL_DATA_WIDTH-1:0]   d_data,
  output logic                       d_error
);

  localparam int LG    = $clog2(TL_STRB_WIDTH);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;
  localparam int LOAD  = (RESP_LATENCY > 0) ? RESP_LATENCY - 1 : 0;

  slave_state_e             state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ready_en_p0;
  logic                     accept;
  logic                     op_ok, range_err, size_err, misalign, req_err;
  logic                     is_get;
  logic [TL_ADDR_WIDTH-1:0] offset, word_idx;
  logic [TL_DATA_WIDTH-1:0] ram_rdata;
  logic                     good_get_p1;
  logic [TL_OPCODE_WIDTH-1:0] d_opcode_p1;
  logic [TL_SIZE_WIDTH-1:0]   d_size_p1;
  logic [TL_SOURCE_WIDTH-1:0] d_source_p1;
  logic                       d_error_p1;
  logic                       unused_param;

  assign unused_param = ^a_param;
  assign is_get       = (a_opcode == GET_A);
  assign accept       = a_valid && a_ready;

  // Request decode: legal opcode, address window, size and alignment
  always_comb begin
    op_ok = (a_opcode == PUT_FULL_DATA_A) || is_get;
`ifdef TL_UL_SLAVE_PARTIAL_EN
    op_ok = op_ok || (a_opcode == PUT_PARTIAL_DATA_A);
`endif
    offset    = a_address - BASE_ADDR;
    word_idx  = offset >> LG;
    range_err = (a_address < BASE_ADDR) || (word_idx >= TL_ADDR_WIDTH'(MEM_DEPTH));
    size_err  = (a_size > TL_SIZE_WIDTH'(LG));
    misalign  = 1'b0;
    for (int i = 0; i < LG; i++) begin
      if (a_address[i] && (TL_SIZE_WIDTH'(i) < a_size)) misalign = 1'b1;
    end
    req_err = range_err || size_err || misalign || !op_ok;
  end

  // Memory is touched only on the acceptance edge of a good request
  tl_ul_slave_ram #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (TL_DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (accept && !req_err),
    .we    (!is_get),
    .be    ((a_opcode == PUT_FULL_DATA_A) ? {TL_STRB_WIDTH{1'b1}} : a_mask),
    .addr  (word_idx[IDX_W-1:0]),
    .wdata (a_data),
    .rdata (ram_rdata)
  );

  // ---- stage p0: out-of-reset qualifier for a_ready ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en_p0 <= 1'b0;
    else     ready_en_p0 <= 1'b1;
  end

  // FSM state and latency counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_ready = 1'b0;
    d_valid = 1'b0;
    case (state_q)
      IDLE: begin
        a_ready = ready_en_p0;
        if (a_valid && ready_en_p0) begin
          if (RESP_LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LOAD);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP: begin
        d_valid = 1'b1;
        if (d_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p1: response fields captured at acceptance, held until the next request ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_opcode_p1 <= '0;
      d_size_p1   <= '0;
      d_source_p1 <= '0;
      d_error_p1  <= 1'b0;
      good_get_p1 <= 1'b0;
    end else if (accept) begin
      d_opcode_p1 <= is_get ? ACCESS_ACK_DATA_D : ACCESS_ACK_D;
      d_size_p1   <= a_size;
      d_source_p1 <= a_source;
      d_error_p1  <= req_err;
      good_get_p1 <= is_get && !req_err;
    end
  end

  assign d_opcode = d_opcode_p1;
  assign d_param  = '0;
  assign d_size   = d_size_p1;
  assign d_sink   = TL_SINK_WIDTH'(SINK_ID);
  assign d_source = d_source_p1;
  assign d_error  = d_error_p1;
  assign d_data   = good_get_p1 ? ram_rdata : '0;

endmodule

// File: tb/tb_tilelink_ul_slave_mem.sv
// Scoreboard bench for tilelink_ul_slave_mem: stimulus pushes the expected
// D response, a negedge monitor pops and compares on each D handshake.
module tb_tilelink_ul_slave_mem;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_param = '0;
  logic [63:0] a_address = '0;
  logic [7:0]  a_size = '0;
  logic [7:0]  a_mask = '0;
  logic [63:0] a_data = '0;
  logic [2:0]  a_source = '0;
  logic        d_valid;
  logic        d_ready = 1'b1;
  logic [2:0]  d_opcode, d_param, d_sink, d_source;
  logic [7:0]  d_size;
  logic [63:0] d_data;
  logic        d_error;

  // Second instance: zero latency, offset window, small depth
  logic        a2_valid = 1'b0;
  logic        a2_ready;
  logic [2:0]  a2_opcode = '0;
  logic [63:0] a2_address = '0;
  logic [63:0] a2_data = '0;
  logic [2:0]  a2_source = '0;
  logic        d2_valid;
  logic        d2_ready = 1'b1;
  logic [2:0]  d2_opcode, d2_param, d2_sink, d2_source;
  logic [7:0]  d2_size;
  logic [63:0] d2_data;
  logic        d2_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  src;
    logic [7:0]  sz;
    logic [63:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_valid = 1'b0;

  tilelink_ul_slave_mem #(.RESP_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_address(a_address), .a_size(a_size), .a_mask(a_mask), .a_data(a_data),
    .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_sink(d_sink), .d_source(d_source), .d_data(d_data),
    .d_error(d_error)
  );

  tilelink_ul_slave_mem #(.RESP_LATENCY(0), .MEM_DEPTH(16), .BASE_ADDR(64'h1000)) dut2 (
    .clk(clk), .rst(rst),
    .a_valid(a2_valid), .a_ready(a2_ready), .a_opcode(a2_opcode), .a_param(3'd0),
    .a_address(a2_address), .a_size(8'd3), .a_mask(8'hFF), .a_data(a2_data),
    .a_source(a2_source),
    .d_valid(d2_valid), .d_ready(d2_ready), .d_opcode(d2_opcode), .d_param(d2_param),
    .d_size(d2_size), .d_sink(d2_sink), .d_source(d2_source), .d_data(d2_data),
    .d_error(d2_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one A request; optionally push its expected D response
  task automatic send(input logic [2:0] op, input logic [63:0] addr, input logic [7:0] sz,
                      input logic [7:0] mask, input logic [63:0] data, input logic [2:0] src,
                      input logic [2:0] eop, input logic [63:0] edata, input logic eerr,
                      input bit push);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!a_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_ready) begin
      chk("a_ready_timeout", 64'(a_ready), 64'd1);
      return;
    end
    a_opcode = op; a_address = addr; a_size = sz; a_mask = mask;
    a_data = data; a_source = src; a_valid = 1'b1;
    if (push) begin
      e.op = eop; e.src = src; e.sz = sz; e.data = edata; e.err = eerr;
      e.cyc = cyc + 1 + LAT;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 a_valid = 1'b0;
  endtask

  // Monitor: latency on d_valid rise, field compare on each D handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (d_valid && !prev_valid) begin
        if (exp_q.size() == 0) chk("unexpected_d_valid", 64'(d_valid), 64'd0);
        else                   chk("latency", 64'(cyc), 64'(exp_q[0].cyc));
      end
      if (d_valid && d_ready && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("d_opcode", 64'(d_opcode), 64'(mon_e.op));
        chk("d_source", 64'(d_source), 64'(mon_e.src));
        chk("d_size",   64'(d_size),   64'(mon_e.sz));
        chk("d_data",   d_data,        mon_e.data);
        chk("d_error",  64'(d_error),  64'(mon_e.err));
        chk("d_param",  64'(d_param),  64'd0);
        chk("d_sink",   64'(d_sink),   64'd0);
      end
    end
    prev_valid = rst ? 1'b0 : d_valid;
  end

  logic [63:0] w10, s_data;
  logic [2:0]  s_op, s_src;
  logic        s_err;
  logic        part_err;

  initial begin
    int n;
`ifdef TL_UL_SLAVE_PARTIAL_EN
    w10 = 64'hDEADBEEF_55667788;
    part_err = 1'b0;
`else
    w10 = 64'hDEADBEEF_CAFEF00D;
    part_err = 1'b1;
`endif
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_d_valid", 64'(d_valid), 64'd0);
    chk("rst_d_data",  d_data,       64'd0);
    chk("rst_d_opcode", 64'(d_opcode), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(a_ready), 64'd1);

    // Basic put/get, partial, errors
    send(3'd0, 64'h10, 8'd3, 8'hFF, 64'hDEADBEEF_CAFEF00D, 3'd3, 3'd0, 64'd0, 1'b0, 1);
    send(3'd4, 64'h10, 8'd3, 8'hFF, 64'd0, 3'd1, 3'd1, 64'hDEADBEEF_CAFEF00D, 1'b0, 1);
    send(3'd1, 64'h10, 8'd3, 8'h0F, 64'h11223344_55667788, 3'd2, 3'd0, 64'd0, part_err, 1);
    send(3'd4, 64'h10, 8'd3, 8'hFF, 64'd0, 3'd0, 3'd1, w10, 1'b0, 1);
    send(3'd4, 64'h800, 8'd3, 8'hFF, 64'd0, 3'd4, 3'd1, 64'd0, 1'b1, 1);
    send(3'd4, 64'h12, 8'd3, 8'hFF, 64'd0, 3'd5, 3'd1, 64'd0, 1'b1, 1);
    send(3'd6, 64'h10, 8'd3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd6, 3'd0, 64'd0, 1'b1, 1);
    send(3'd2, 64'h10, 8'd3, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 3'd7, 3'd0, 64'd0, 1'b1, 1);
    send(3'd0, 64'h10, 8'd4, 8'hFF, 64'h5555_5555_5555_5555, 3'd1, 3'd0, 64'd0, 1'b1, 1);
    send(3'd4, 64'h10, 8'd4, 8'hFF, 64'd0, 3'd2, 3'd1, 64'd0, 1'b1, 1);
    send(3'd4, 64'h14, 8'd2, 8'hFF, 64'd0, 3'd3, 3'd1, w10, 1'b0, 1);
    send(3'd4, 64'h10, 8'd3, 8'hFF, 64'd0, 3'd4, 3'd1, w10, 1'b0, 1);
    send(3'd0, 64'h7F8, 8'd3, 8'h00, 64'h01234567_89ABCDEF, 3'd5, 3'd0, 64'd0, 1'b0, 1);
    send(3'd4, 64'h7F8, 8'd3, 8'hFF, 64'd0, 3'd6, 3'd1, 64'h01234567_89ABCDEF, 1'b0, 1);

    // Backpressure: d_ready low, outputs must hold
    @(negedge clk);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    d_ready = 1'b0;
    send(3'd4, 64'h7F8, 8'd3, 8'hFF, 64'd0, 3'd2, 3'd1, 64'h01234567_89ABCDEF, 1'b0, 1);
    n = 0;
    @(negedge clk);
    while (!d_valid && n < 20) begin @(negedge clk); n++; end
    chk("stall_valid", 64'(d_valid), 64'd1);
    s_data = d_data; s_op = d_opcode; s_src = d_source; s_err = d_error;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold_valid", 64'(d_valid), 64'd1);
      chk("stall_hold_data", d_data, s_data);
      chk("stall_hold_op", {58'd0, s_err, d_opcode, d_source[0]},
          {58'd0, d_error, s_op, s_src[0]});
      chk("stall_a_ready", 64'(a_ready), 64'd0);
    end
    @(posedge clk);
    #1 d_ready = 1'b1;
    @(negedge clk);
    chk("hs_cycle_a_ready", 64'(a_ready), 64'd0);
    @(negedge clk);
    chk("post_hs_a_ready", 64'(a_ready), 64'd1);

    // Reset while a write response is in WAIT
    send(3'd0, 64'h20, 8'd3, 8'hFF, 64'hA5A5_A5A5_0F0F_0F0F, 3'd1, 3'd0, 64'd0, 1'b0, 1);
    send(3'd0, 64'h28, 8'd3, 8'hFF, 64'h5A5A_1234_5678_9ABC, 3'd2, 3'd0, 64'd0, 1'b0, 0);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_a_ready", 64'(a_ready), 64'd0);
    chk("midrst_d_valid", 64'(d_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", 64'(a_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("dropped_resp", 64'(d_valid), 64'd0);
    end
    send(3'd4, 64'h28, 8'd3, 8'hFF, 64'd0, 3'd3, 3'd1, 64'h5A5A_1234_5678_9ABC, 1'b0, 1);
    send(3'd4, 64'h20, 8'd3, 8'hFF, 64'd0, 3'd4, 3'd1, 64'hA5A5_A5A5_0F0F_0F0F, 1'b0, 1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    // Zero-latency instance with offset window
    @(negedge clk);
    a2_opcode = 3'd0; a2_address = 64'h1008; a2_data = 64'hC0FFEE00_12345678;
    a2_source = 3'd4; a2_valid = 1'b1;
    @(posedge clk);
    #1 a2_valid = 1'b0;
    @(negedge clk);
    chk("lat0_put_valid", 64'(d2_valid), 64'd1);
    chk("lat0_put_op", 64'(d2_opcode), 64'd0);
    chk("lat0_put_src", 64'(d2_source), 64'd4);
    chk("lat0_put_err", 64'(d2_error), 64'd0);
    @(negedge clk);
    chk("lat0_ready", 64'(a2_ready), 64'd1);
    a2_opcode = 3'd4; a2_address = 64'h1008; a2_source = 3'd7; a2_valid = 1'b1;
    @(posedge clk);
    #1 a2_valid = 1'b0;
    @(negedge clk);
    chk("lat0_get_valid", 64'(d2_valid), 64'd1);
    chk("lat0_get_op", 64'(d2_opcode), 64'd1);
    chk("lat0_get_data", d2_data, 64'hC0FFEE00_12345678);
    @(negedge clk);
    a2_opcode = 3'd4; a2_address = 64'h0FF8; a2_source = 3'd1; a2_valid = 1'b1;
    @(posedge clk);
    #1 a2_valid = 1'b0;
    @(negedge clk);
    chk("below_base_err", 64'(d2_error), 64'd1);
    chk("below_base_data", d2_data, 64'd0);
    @(negedge clk);
    a2_opcode = 3'd4; a2_address = 64'h1080; a2_source = 3'd2; a2_valid = 1'b1;
    @(posedge clk);
    #1 a2_valid = 1'b0;
    @(negedge clk);
    chk("above_depth_err", 64'(d2_error), 64'd1);
    chk("above_depth_op", 64'(d2_opcode), 64'd1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
